weight_init: RTL and testbench

WEIGHT_INIT -- requirements
Module: weight_init

---
 rtl/weight_init.sv | 107 ++++++++++
 tb/tb_weight_init.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/weight_init.sv
// Weight initialiser: streams NUM_WEIGHTS pseudo-random weights from an LFSR word into a weight memory.
// Map select: define WEIGHT_INIT_GAUSS_EN for the sum-of-bytes Gaussian map, otherwise uniform shifted map.
module weight_init #(
  parameter int NUM_WEIGHTS = 7840,
  parameter int ADDR_W      = 13,
  parameter int SHIFT       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       lfsr_value,
  input  logic              start,
  input  logic              abort,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic [1:0]        fsm_state
);

  // Handshake: a word moves on every rising edge where wr_valid and wr_ready are both high;
  // while wr_valid is high and wr_ready low, wr_addr/wr_data hold.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_WEIGHTS - 1);

  state_t state;

  assign fsm_state = state;

`ifdef WEIGHT_INIT_GAUSS_EN
  // Sum of four signed bytes approximates a bell curve; scaled by 4 (range -2048..2032).
  function automatic logic [15:0] map_word(input logic [31:0] v);
    logic signed [15:0] s;
    s = $signed({{8{v[7]}},  v[7:0]})   + $signed({{8{v[15]}}, v[15:8]})
      + $signed({{8{v[23]}}, v[23:16]}) + $signed({{8{v[31]}}, v[31:24]});
    return {s[13:0], 2'b00};
  endfunction
`else
  logic unused_hi;
  assign unused_hi = ^lfsr_value[31:16];

  function automatic logic [15:0] map_word(input logic [31:0] v);
    logic signed [15:0] s;
    s = $signed(v[15:0]);
    return s >>> SHIFT;
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (abort) begin
            state <= IDLE;
            done  <= 1'b0;
          end else if (start) begin
            state    <= FILL;
            wr_valid <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= map_word(lfsr_value);
          end
        end
        FILL: begin
          // A transfer coinciding with abort completes at the memory; nothing further is issued.
          if (abort) begin
            state    <= IDLE;
            wr_valid <= 1'b0;
            busy     <= 1'b0;
          end else if (wr_ready) begin
            if (wr_addr == LAST) begin
              state    <= DONE;
              wr_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              wr_addr <= wr_addr + ADDR_W'(1);
              wr_data <= map_word(lfsr_value);
            end
          end
        end
        default: begin
          state    <= IDLE;
          wr_valid <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weight_init.sv
// Bench for weight_init: transaction-level model with per-cycle compare plus directed literal vectors.
// Honours WEIGHT_INIT_GAUSS_EN for the map under test.
module tb_weight_init;

  localparam int N      = 110;
  localparam int AW     = 7;
  localparam int SH     = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   lfsr = 32'h0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          wr_ready = 1'b0;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic          busy;
  logic          done;
  logic [1:0]    fsm_state;

  logic          start4 = 1'b0;
  logic          wr_valid4;
  logic [1:0]    wr_addr4;
  logic [15:0]   wr_data4;
  logic          busy4;
  logic          done4;
  logic [1:0]    fsm_state4;

  int checks = 0;
  int failures = 0;
  int xfer_cnt = 0;

  always #5 clk = ~clk;

  weight_init #(.NUM_WEIGHTS(N), .ADDR_W(AW), .SHIFT(SH)) dut (
    .clk(clk), .rst_n(rst_n), .lfsr_value(lfsr), .start(start), .abort(abort),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .fsm_state(fsm_state)
  );

  weight_init #(.NUM_WEIGHTS(4), .ADDR_W(2), .SHIFT(SH)) dut4 (
    .clk(clk), .rst_n(rst_n), .lfsr_value(lfsr), .start(start4), .abort(1'b0),
    .wr_valid(wr_valid4), .wr_ready(1'b1), .wr_addr(wr_addr4), .wr_data(wr_data4),
    .busy(busy4), .done(done4), .fsm_state(fsm_state4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Map from the arithmetic definition, not bit manipulation.
  function automatic logic [15:0] model_map(input logic [31:0] v);
    int s;
    int d;
    s = 0;
`ifdef WEIGHT_INIT_GAUSS_EN
    d = 0;
    for (int i = 0; i < 4; i++) s += int'($signed(v[8*i +: 8]));
    return 16'(s * 4);
`else
    s = int'($signed(v[15:0]));
    d = 1 << SH;
    if (s >= 0) return 16'(s / d);
    return 16'(-((-s + d - 1) / d));
`endif
  endfunction

  // Model: is a word on offer, which index, what value, did the last fill complete.
  logic        m_valid = 1'b0;
  logic        m_done = 1'b0;
  int          m_addr = 0;
  logic [15:0] m_data = 16'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0; m_done = 1'b0; m_addr = 0; m_data = 16'h0;
    end else if (m_valid) begin
      if (abort) m_valid = 1'b0;
      else if (wr_ready) begin
        if (m_addr == N - 1) begin
          m_valid = 1'b0; m_done = 1'b1;
        end else begin
          m_addr = m_addr + 1; m_data = model_map(lfsr);
        end
      end
    end else if (abort) m_done = 1'b0;
    else if (start) begin
      m_valid = 1'b1; m_done = 1'b0; m_addr = 0; m_data = model_map(lfsr);
    end
  end

  always @(posedge clk) if (rst_n && wr_valid && wr_ready) xfer_cnt++;

  always @(negedge clk) begin
    check("valid", 32'(wr_valid), 32'(m_valid));
    check("busy", 32'(busy), 32'(m_valid));
    check("done", 32'(done), 32'(m_done));
    check("addr", 32'(wr_addr), 32'(m_addr));
    check("data", 32'(wr_data), 32'(m_data));
    if (wr_valid) check("addr_range", 32'(int'(wr_addr) < N), 32'd1);
  end

  task automatic step();
    @(negedge clk);
    lfsr = $urandom();
  endtask

  task automatic wait_addr(input int a, input bit rnd);
    int n;
    n = 0;
    while (!(wr_valid === 1'b1 && int'(wr_addr) == a) && n < 1000) begin
      step();
      if (rnd) wr_ready = 1'($urandom_range(0, 1));
      n++;
    end
    check("wait_addr", 32'(wr_addr), 32'(a));
  endtask

  logic [31:0] vec [3];
  logic [15:0] lit [3];
  logic [15:0] d2;
  int          n;

  initial begin
`ifdef WEIGHT_INIT_GAUSS_EN
    vec[0] = 32'h8080_8080; lit[0] = 16'hF800;
    vec[1] = 32'h7F7F_7F7F; lit[1] = 16'h07F0;
    vec[2] = 32'h0000_0000; lit[2] = 16'h0000;
`else
    vec[0] = 32'h0000_8000; lit[0] = 16'hF800;
    vec[1] = 32'h0000_7FFF; lit[1] = 16'h07FF;
    vec[2] = 32'h0000_0000; lit[2] = 16'h0000;
`endif
    for (int i = 0; i < 3; i++) check("model_pin", 32'(model_map(vec[i])), 32'(lit[i]));

    repeat (3) step();
    check("rst_valid", 32'(wr_valid), 32'd0);
    check("rst_addr", 32'(wr_addr), 32'd0);
    check("rst_data", 32'(wr_data), 32'd0);
    check("rst_busy_done", {busy, done}, 32'd0);
    check("rst_state", 32'(fsm_state), 32'd0);
    rst_n = 1'b1;
    repeat (3) step();
    check("idle_after_rst", {wr_valid, busy, done}, 32'd0);

    // Directed map vectors, each fill cancelled by abort.
    for (int i = 0; i < 3; i++) begin
      step();
      lfsr = vec[i]; start = 1'b1;
      step();
      start = 1'b0;
      check("vec_data", 32'(wr_data), 32'(lit[i]));
      check("vec_first", {wr_valid, 7'(wr_addr)}, 32'h80);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort_valid", 32'(wr_valid), 32'd0);
    end

    // Stall at index 2, ignored start at 7, async reset at 100.
    step();
    start = 1'b1; wr_ready = 1'b1;
    step();
    start = 1'b0;
    wait_addr(2, 1'b0);
    wr_ready = 1'b0; d2 = wr_data;
    repeat (5) begin
      step();
      check("stall_addr", 32'(wr_addr), 32'd2);
      check("stall_data", 32'(wr_data), 32'(d2));
    end
    wr_ready = 1'b1;
    step();
    check("stall_release", 32'(wr_addr), 32'd3);
    wait_addr(7, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_ignored", {busy, 7'(wr_addr)}, 32'h88);
    wait_addr(100, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst", {wr_valid, busy, done, 16'(wr_addr)}, 32'd0);
    check("async_rst_data", 32'(wr_data), 32'd0);
    check("async_rst_state", 32'(fsm_state), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Complete fill with random back-pressure.
    xfer_cnt = 0;
    start = 1'b1; wr_ready = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      step();
      wr_ready = 1'($urandom_range(0, 1));
      n++;
    end
    check("fill_done", 32'(done), 32'd1);
    check("fill_count", 32'(xfer_cnt), 32'(N));
    check("done_addr_hold", 32'(wr_addr), 32'(N - 1));
    step();
    abort = 1'b1; start = 1'b1;
    step();
    abort = 1'b0; start = 1'b0;
    check("abort_start_done", {wr_valid, busy, done}, 32'd0);
    check("abort_start_state", 32'(fsm_state), 32'd0);

    // Four-word instance, always ready.
    step();
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("n4_seq", {wr_valid4, 2'(wr_addr4)}, 32'(4 + k));
      step();
    end
    check("n4_done", {done4, wr_valid4, busy4}, 32'h4);

    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
